// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared fetch-side types for the instruction prefetch path.
// Entry layout, request FSM states and default sizing.
package instr_prefetch_buffer_pkg;

  localparam int FETCH_MAX_OUT = 2;
  localparam int FETCH_DEPTH   = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fetch_entry_t;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } req_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Head and valid are registered: no input-to-output path.
module fetch_fifo
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          do_push, do_pop, bypass;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (cnt != '0);
  assign do_push = push_i && ((cnt != FULL) || do_pop);
  assign count_o = cnt;

  always_comb begin
    rd_ptr_n = do_pop ? inc(rd_ptr) : rd_ptr;
    cnt_n    = cnt;
    if (do_push && !do_pop)
      cnt_n = cnt + 1'b1;
    else if (do_pop && !do_push)
      cnt_n = cnt - 1'b1;
    // new word becomes head when it lands in an empty slot
    bypass = do_push && (cnt_n == CW'(1));
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i)
      mem[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_n;
      cnt     <= cnt_n;
      valid_o <= (cnt_n != '0);
      if (do_push)
        wr_ptr <= inc(wr_ptr);
      if (cnt_n != '0)
        head_o <= bypass ? wdata_i : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch: bus request FSM, response FIFO
// and redirect handling with in-flight response discard.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH   = FETCH_DEPTH,
  parameter int MAX_OUT = FETCH_MAX_OUT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] boot_addr_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  req_state_e   state;
  logic         boot_done, stale;
  logic [31:0]  fetch_addr, req_addr, next_addr;
  logic [OW-1:0] out_cnt, out_cnt_n;
  logic [OW-1:0] discard_cnt, discard_n;
  logic [FW-1:0] fifo_cnt, fifo_cnt_n;
  logic         gnt, rsp_v, drop, push, pop;
  logic         issue, aq_valid;
  fetch_entry_t aq_wdata, aq_head, rsp, head;

  assign gnt   = (state == S_REQ) && instr_gnt_i;
  assign rsp_v = instr_rvalid_i && aq_valid;
  assign drop  = branch_i || (discard_cnt != '0);
  assign push  = rsp_v && !drop;
  assign pop   = valid_o && ready_i && !branch_i;

  assign out_cnt_n  = out_cnt + OW'(gnt) - OW'(rsp_v);
  assign fifo_cnt_n = branch_i ? '0
                    : fifo_cnt + FW'(push) - FW'(pop);

  assign issue = boot_done && req_i
              && (int'(out_cnt_n) < MAX_OUT)
              && (int'(fifo_cnt_n) + int'(out_cnt_n) < DEPTH);

  // a stale grant must not advance: fetch_addr already holds the target
  assign next_addr = branch_i ? word_align(branch_addr_i)
                   : (gnt && !stale) ? fetch_addr + 32'd4
                   : fetch_addr;

  always_comb begin
    discard_n = discard_cnt;
    if (branch_i) begin
      discard_n = out_cnt_n;
    end else begin
      if (rsp_v && (discard_cnt != '0))
        discard_n = discard_n - 1'b1;
      if (gnt && stale)
        discard_n = discard_n + 1'b1;
    end
  end

  always_comb begin
    aq_wdata      = '0;
    aq_wdata.addr = req_addr;
    rsp           = aq_head;
    rsp.data      = instr_rdata_i;
    rsp.err       = instr_err_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      boot_done   <= 1'b0;
      stale       <= 1'b0;
      fetch_addr  <= '0;
      req_addr    <= '0;
      discard_cnt <= '0;
    end else begin
      discard_cnt <= discard_n;
      if (!boot_done) begin
        boot_done  <= 1'b1;
        fetch_addr <= word_align(boot_addr_i);
      end else begin
        fetch_addr <= next_addr;
      end
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            state    <= S_REQ;
            req_addr <= next_addr;
          end
        end
        S_REQ: begin
          if (gnt) begin
            stale <= 1'b0;
            if (issue)
              req_addr <= next_addr;
            else
              state <= S_IDLE;
          end else if (branch_i) begin
            stale <= 1'b1;
          end
        end
      endcase
    end
  end

  fetch_fifo #(.DEPTH(MAX_OUT)) u_addr_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (gnt),
    .wdata_i (aq_wdata),
    .pop_i   (instr_rvalid_i),
    .valid_o (aq_valid),
    .head_o  (aq_head),
    .count_o (out_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (branch_i),
    .push_i  (push),
    .wdata_i (rsp),
    .pop_i   (pop),
    .valid_o (valid_o),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign rdata_o      = head.data;
  assign addr_o       = head.addr;
  assign err_o        = head.err;
  assign instr_req_o  = (state == S_REQ);
  assign instr_addr_o = req_addr;
  assign busy_o       = (state == S_REQ) || (out_cnt != '0);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a
// zero-wait memory model and per-cycle vector table.
module tb_instr_prefetch_buffer;
  import instr_prefetch_buffer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] boot_addr_i = 32'h80;
  logic        req_i = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o, err_o, busy_o, instr_req_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;

  logic        gnt_en = 1'b1;
  logic        rv_en = 1'b1;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] rsp_addr;

  int checks = 0;
  int failures = 0;

  logic [31:0]  pend[$];
  logic [31:0]  gnt_log[$];
  fetch_entry_t pop_log[$];

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] iaddr;
    logic        vld;
    logic [31:0] haddr;
    logic        busy;
  } vec_t;

  vec_t tbl[16];

  instr_prefetch_buffer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .boot_addr_i    (boot_addr_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  assign instr_gnt_i = instr_req_o & gnt_en;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // zero-wait memory: a grant seen at an edge answers in the next cycle
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      pend.delete();
      gnt_log.delete();
      pop_log.delete();
      #1;
      instr_rvalid_i = 1'b0;
      instr_err_i = 1'b0;
    end else begin
      if (instr_req_o && instr_gnt_i) begin
        pend.push_back(instr_addr_o);
        gnt_log.push_back(instr_addr_o);
      end
      if (valid_o && ready_i && !branch_i)
        pop_log.push_back('{addr_o, rdata_o, err_o});
      #1;
      if (rv_en && pend.size() != 0) begin
        rsp_addr = pend.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i = mdata(rsp_addr);
        instr_err_i = (rsp_addr == err_addr);
      end else begin
        instr_rvalid_i = 1'b0;
        instr_err_i = 1'b0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] boot);
    @(negedge clk_i);
    rst_ni = 1'b0;
    branch_i = 1'b0;
    ready_i = 1'b0;
    req_i = 1'b1;
    gnt_en = 1'b1;
    rv_en = 1'b1;
    err_addr = 32'h1;
    boot_addr_i = boot;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pop_log.size() < n && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("pop_wait", 32'(pop_log.size() >= n), 32'd1);
  endtask

  task automatic chk_pop(input string nm, input int i,
                         input logic [31:0] a,
                         input logic e);
    if (pop_log.size() > i) begin
      chk({nm, "_addr"}, pop_log[i].addr, a);
      chk({nm, "_data"}, pop_log[i].data, mdata(a));
      chk({nm, "_err"}, 32'(pop_log[i].err), 32'(e));
    end else begin
      chk({nm, "_missing"}, 32'(pop_log.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int n;
    tbl[0]  = '{0, 0, 32'h00, 0, 32'h00, 0};
    tbl[1]  = '{0, 1, 32'h80, 0, 32'h00, 1};
    tbl[2]  = '{0, 1, 32'h84, 0, 32'h00, 1};
    tbl[3]  = '{0, 1, 32'h88, 1, 32'h80, 1};
    tbl[4]  = '{0, 1, 32'h8C, 1, 32'h80, 1};
    tbl[5]  = '{0, 0, 32'h00, 1, 32'h80, 1};
    tbl[6]  = '{0, 0, 32'h00, 1, 32'h80, 0};
    tbl[7]  = '{0, 0, 32'h00, 1, 32'h80, 0};
    tbl[8]  = '{1, 1, 32'h90, 1, 32'h84, 1};
    tbl[9]  = '{0, 0, 32'h00, 1, 32'h84, 1};
    tbl[10] = '{0, 0, 32'h00, 1, 32'h84, 0};
    tbl[11] = '{1, 1, 32'h94, 1, 32'h88, 1};
    tbl[12] = '{1, 1, 32'h98, 1, 32'h8C, 1};
    tbl[13] = '{1, 1, 32'h9C, 1, 32'h90, 1};
    tbl[14] = '{1, 1, 32'hA0, 1, 32'h94, 1};
    tbl[15] = '{1, 1, 32'hA4, 1, 32'h98, 1};

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_iaddr", instr_addr_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // boot, fill under backpressure, single pop, streaming
    boot_addr_i = 32'h83;
    rst_ni = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ready_i = tbl[i].rdy;
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("row%0d_req", i), 32'(instr_req_o), 32'(tbl[i].req));
      if (tbl[i].req)
        chk($sformatf("row%0d_iaddr", i), instr_addr_o, tbl[i].iaddr);
      chk($sformatf("row%0d_valid", i), 32'(valid_o), 32'(tbl[i].vld));
      chk($sformatf("row%0d_addr", i), addr_o, tbl[i].haddr);
      chk($sformatf("row%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
      if (tbl[i].vld) begin
        chk($sformatf("row%0d_rdata", i), rdata_o, mdata(tbl[i].haddr));
        chk($sformatf("row%0d_err", i), 32'(err_o), 32'd0);
      end
    end

    // bus error tagging
    do_reset(32'h80);
    err_addr = 32'h84;
    ready_i = 1'b1;
    wait_pops(3);
    chk_pop("err0", 0, 32'h80, 1'b0);
    chk_pop("err1", 1, 32'h84, 1'b1);
    chk_pop("err2", 2, 32'h88, 1'b0);

    // redirect with two outstanding
    do_reset(32'h100);
    rv_en = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("out2_req", 32'(instr_req_o), 32'd0);
    chk("out2_busy", 32'(busy_o), 32'd1);
    branch_i = 1'b1;
    branch_addr_i = 32'h203;
    rv_en = 1'b1;
    @(negedge clk_i);
    branch_i = 1'b0;
    wait_pops(3);
    chk_pop("rd2_0", 0, 32'h200, 1'b0);
    chk_pop("rd2_1", 1, 32'h204, 1'b0);
    chk_pop("rd2_2", 2, 32'h208, 1'b0);

    // redirect while the request is ungranted
    do_reset(32'h90);
    gnt_en = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("ug_req", 32'(instr_req_o), 32'd1);
    chk("ug_addr", instr_addr_o, 32'h90);
    branch_i = 1'b1;
    branch_addr_i = 32'h400;
    @(negedge clk_i);
    branch_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("ug_hold_req", 32'(instr_req_o), 32'd1);
    chk("ug_hold_addr", instr_addr_o, 32'h90);
    gnt_en = 1'b1;
    wait_pops(2);
    chk("ug_gnt0", (gnt_log.size() > 0) ? gnt_log[0] : 32'hX, 32'h90);
    chk("ug_gnt1", (gnt_log.size() > 1) ? gnt_log[1] : 32'hX, 32'h400);
    chk_pop("ug_0", 0, 32'h400, 1'b0);
    chk_pop("ug_1", 1, 32'h404, 1'b0);

    // branch, rvalid and pop in one cycle while streaming
    do_reset(32'h80);
    ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    chk("sim_pre_valid", 32'(valid_o), 32'd1);
    chk("sim_pre_rvalid", 32'(instr_rvalid_i), 32'd1);
    n = pop_log.size();
    branch_i = 1'b1;
    branch_addr_i = 32'h300;
    @(negedge clk_i);
    branch_i = 1'b0;
    chk("sim_flushed", 32'(valid_o), 32'd0);
    wait_pops(n + 3);
    chk_pop("sim_0", n, 32'h300, 1'b0);
    chk_pop("sim_1", n + 1, 32'h304, 1'b0);
    chk_pop("sim_2", n + 2, 32'h308, 1'b0);

    // asynchronous reset mid-stream
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_req", 32'(instr_req_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_rdata", rdata_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch unit between the instruction-memory bus and the core's IF stage. It issues word-aligned fetch requests on the req/gnt/rvalid instruction bus and keeps up to two requests outstanding. Returned words go into a small FIFO. The IF stage pops one instruction per cycle with a valid/ready handshake. On a redirect (branch/jump) it flushes queued words and discards in-flight responses so stale instructions never reach decode.

## Interface
- `DEPTH`, 4: FIFO entries (≥2); entries plus outstanding requests never exceed DEPTH.
- `MAX_OUT`, 2: maximum outstanding (granted, unanswered) bus requests.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `boot_addr_i` in 32: first fetch address after reset.
- `req_i` in 1: fetch enable; while low no new bus request is raised.
- `branch_i` in 1: redirect strobe.
- `branch_addr_i` in 32: redirect target; bits [1:0] ignored.
- `ready_i` in 1: IF stage accepts the current entry (core's not_stall).
- `valid_o` out 1: FIFO head valid.
- `rdata_o` out 32: head instruction word.
- `addr_o` out 32: head word address.
- `err_o` out 1: head fetched with bus error.
- `busy_o` out 1: any request pending or outstanding.
- `instr_req_o` out 1: bus request.
- `instr_addr_o` out 32: bus address, always [1:0]=00.
- `instr_gnt_i` in 1: grant.
- `instr_rvalid_i` in 1: response valid.
- `instr_rdata_i` in 32: response data.
- `instr_err_i` in 1: response error, qualified by rvalid.

## Operation
- Reset: every output 0; fetch_addr=0, FIFO empty, out_cnt=0, discard_cnt=0, `boot_done`=0.
- First cycle after reset release: fetch_addr<=`boot_addr_i` & ~3, `boot_done`<=1. No request is raised in that cycle.
- Request FSM has two states:
  - IDLE → REQ when `boot_done` & `req_i` & (out_cnt_next < MAX_OUT) & (fifo_cnt_next + out_cnt_next < DEPTH).
  - REQ holds `instr_req_o`=1 with a stable `instr_addr_o` until `instr_gnt_i`.
  - On grant: fetch_addr += 4 (32-bit wrap, 0xFFFF_FFFC → 0) and out_cnt++. Go to REQ with the new address if the issue condition still holds, else IDLE.
- Response: `instr_rvalid_i` decrements out_cnt. If discard_cnt>0, decrement it and drop the word; else push {addr, data, err}. Push address comes from a small per-outstanding address queue of MAX_OUT entries.
- Pop: `valid_o` & `ready_i` removes the head.
- Redirect (`branch_i`), highest priority:
  - FIFO cleared; a same-cycle pop is ignored.
  - fetch_addr <= `branch_addr_i` & ~3.
  - discard_cnt <= out_cnt after this cycle's grant and response.
  - A same-cycle rvalid is dropped.
  - A request in REQ not yet granted stays asserted with its old address and is marked stale. Its grant increments discard_cnt, then the FSM re-issues at the target.
- Error words are queued normally, in order; this block takes no other action on errors.
- `busy_o` = (state==REQ) | (out_cnt≠0).

## Timing
- `instr_req_o` and `instr_addr_o` are registered.
- `valid_o`, `rdata_o`, `addr_o`, `err_o` are registered FIFO-head outputs. There is no combinational path from bus inputs to them.
- Latency: request raised at cycle N, granted in N, rvalid in N+1 → `valid_o`=1 at N+2.
- With zero-wait memory and `ready_i`=1 throughput is 1 word/cycle: back-to-back grants with the request held high.
- Full: FIFO full with out_cnt=0 → no request. A pop re-enables issue the next cycle.
- Empty: `valid_o`=0; `rdata_o`/`addr_o` hold their last values.
- Reset asserted mid-transaction: all state clears immediately. Responses arriving after reset release are not expected by the bus contract.

## Structure
- Shared core package: `FETCH_MAX_OUT`, `fetch_entry_t` {addr[31:0], data[31:0], err}, and the request-FSM state enum.
- Sub-module `fetch_fifo`: a synchronous FIFO of `fetch_entry_t`, DEPTH entries, with flush, push, pop and count. It is also used for the address queue with depth MAX_OUT.
- The top level holds the request FSM, counters and redirect logic.

## Test plan
- Boot: `boot_addr_i`=0x80, zero-wait memory → bus addresses 0x80, 0x84, 0x88…; first `valid_o` with `addr_o`=0x80 three cycles after reset release.
- Backpressure: `ready_i`=0 with DEPTH=4 → exactly 4 words fetched, `instr_req_o` stays 0; a single pop → exactly one new request next cycle.
- Redirect with 2 outstanding: `branch_i`, target 0x200 → both old responses dropped; next `valid_o` entry has `addr_o`=0x200; no entry from the old stream ever appears.
- Redirect while ungranted: request at 0x90 stalled (gnt=0), `branch_i` to 0x400 → 0x90 held until gnt and its response dropped; next request is 0x400.
- Error: rvalid with `instr_err_i`=1 at 0x84 → entry `err_o`=1, `addr_o`=0x84; neighbouring entries `err_o`=0.
- Simultaneous events: `branch_i` + rvalid + pop in one cycle → FIFO empty next cycle, discard_cnt correct, no duplicated or lost target word.
